// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter that owns the decoder_2x4 select (w) and drives a registered one-hot grant.
// Optional hold-time limit with forced rotation is compiled in by defining DECODER_ARB_TIMEOUT_EN.
module decoder_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic       grant_valid,
    output logic [1:0] grant_w,
    output logic [0:3] grant_y,
    output logic       preempt
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("decoder_rr_arbiter: MAX_HOLD must be in 2..255");
    end

    logic [0:0] state_q;
    logic [1:0] last_idx;
    logic [3:0] search_req;
    logic       win_found;
    logic [1:0] win_idx;
    logic       owner_req;
    logic       timeout;
    logic       load_grant;
    logic       go_idle;

    // Scan last+1 .. last+4 (2-bit wrap); last_idx itself is checked last.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!rr_pick[2] && r[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    function automatic logic [0:3] onehot(input logic [1:0] w);
        onehot    = 4'b0000;
        onehot[w] = 1'b1;
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        search_req = req;
        if (state_q == GRANT) search_req[grant_w] = 1'b0;
    end

    assign owner_req              = req[grant_w];
    assign {win_found, win_idx}   = rr_pick(search_req, last_idx);
    assign load_grant             = win_found && ((state_q == IDLE) || !owner_req || timeout);
    assign go_idle                = (state_q == GRANT) && !owner_req && !win_found;

`ifdef DECODER_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt;
    logic       hold_expired;

    assign hold_expired = (hold_cnt == HOLD_LAST);
    // Rotation is forced only while the owner still wants the grant and someone else is waiting.
    assign timeout      = (state_q == GRANT) && owner_req && hold_expired && (search_req != 4'b0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 8'd0;
        end else if (load_grant || hold_expired) begin
            hold_cnt <= 8'd0;
        end else if (state_q == GRANT) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_idx    <= 2'd3;
            grant_valid <= 1'b0;
            grant_w     <= 2'd0;
            grant_y     <= 4'b0000;
            preempt     <= 1'b0;
        end else begin
            preempt <= timeout;
            if (load_grant) begin
                state_q     <= GRANT;
                last_idx    <= win_idx;
                grant_valid <= 1'b1;
                grant_w     <= win_idx;
                grant_y     <= onehot(win_idx);
            end else if (go_idle) begin
                state_q     <= IDLE;
                grant_valid <= 1'b0;
                grant_y     <= 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed self-checking bench for decoder_rr_arbiter (MAX_HOLD=4).
// Hold-limit expectations follow DECODER_ARB_TIMEOUT_EN as seen by this compile.
module tb_decoder_rr_arbiter;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic       grant_valid;
    logic [1:0] grant_w;
    logic [0:3] grant_y;
    logic       preempt;
    logic [7:0] obs;
    logic [7:0] e;
    int         n_cmp = 0;
    int         n_err = 0;

    decoder_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .grant_valid(grant_valid),
        .grant_w    (grant_w),
        .grant_y    (grant_y),
        .preempt    (preempt)
    );

    always #5 clk = ~clk;

    // Observed bundle: {valid, w[1:0], y[0], y[1], y[2], y[3], preempt}
    assign obs = {grant_valid, grant_w, grant_y, preempt};

    function automatic logic [7:0] exp_out(input logic v, input logic [1:0] w, input logic p);
        logic [3:0] y;
        y = v ? (4'b1000 >> w) : 4'b0000;
        return {v, w, y, p};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        step();
        n_cmp++;
        if (obs !== 8'b0) begin
            n_err++;
            $display("FAIL reset_held: got %b want %b", obs, 8'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (obs !== 8'b0) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: got %b want %b", i, obs, 8'b0);
            end
        end
    endtask

    task automatic test_rotation();
        apply_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            e = exp_out(1'b1, 2'(i % 4), 1'b0);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL rotation[%0d]: got %b want %b", i, obs, e);
            end
            req = 4'b1111 & ~(4'b0001 << (i % 4));
        end
    endtask

    task automatic test_release();
        apply_reset();
        req = 4'b0100;
        step();
        e = exp_out(1'b1, 2'd2, 1'b0);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL release_grant2: got %b want %b", obs, e);
        end
        req = 4'b0110;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL release_hold2[%0d]: got %b want %b", i, obs, e);
            end
        end
        req = 4'b0010;
        step();
        e = exp_out(1'b1, 2'd1, 1'b0);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL release_handover1: got %b want %b", obs, e);
        end
        req = 4'b0000;
        step();
        n_cmp++;
        if ({grant_valid, grant_y, preempt} !== 6'b0) begin
            n_err++;
            $display("FAIL release_idle: got %b want %b", {grant_valid, grant_y, preempt}, 6'b0);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 4'b1000;
        step();
        e = exp_out(1'b1, 2'd3, 1'b0);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL areset_grant3: got %b want %b", obs, e);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 8'b0) begin
            n_err++;
            $display("FAIL areset_midcycle: got %b want %b", obs, 8'b0);
        end
        step();
        rst_n = 1'b1;
        req   = 4'b1000;
        step();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL areset_regrant3: got %b want %b", obs, e);
        end
        apply_reset();
        req = 4'b1001;
        step();
        e = exp_out(1'b1, 2'd0, 1'b0);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL areset_priority0: got %b want %b", obs, e);
        end
    endtask

    task automatic test_single_owner();
        apply_reset();
        req = 4'b0001;
        e   = exp_out(1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL single_owner[%0d]: got %b want %b", i, obs, e);
            end
        end
    endtask

    task automatic test_hold_limit();
        apply_reset();
        req = 4'b0011;
`ifdef DECODER_ARB_TIMEOUT_EN
        for (int i = 0; i < 6; i++) begin
            step();
            if (i < 4)       e = exp_out(1'b1, 2'd0, 1'b0);
            else if (i == 4) e = exp_out(1'b1, 2'd1, 1'b1);
            else             e = exp_out(1'b1, 2'd1, 1'b0);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL hold_limit[%0d]: got %b want %b", i, obs, e);
            end
        end
`else
        e = exp_out(1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL no_hold_limit[%0d]: got %b want %b", i, obs, e);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_release();
        test_async_reset();
        test_single_owner();
        test_hold_limit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
